// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter: one launch pulse per byte, then waits out the frame.
// Optional clear-to-send gating is enabled by defining UART_TX_QUEUE_CTS_EN.
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  all_sent,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  input  logic                  uart_busy
`ifdef UART_TX_QUEUE_CTS_EN
  ,
  input  logic                  cts_n
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {
    Q_IDLE,
    Q_LAUNCH,
    Q_WAIT_BUSY,
    Q_WAIT_DONE
  } state_e;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] head_q, tail_q;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  state_e                state_q;
  logic                  transmit_q;
  logic [7:0]            tx_byte_q;
  logic                  full, push, pop, cts_ok;

`ifdef UART_TX_QUEUE_CTS_EN
  assign cts_ok = ~cts_n;
`else
  assign cts_ok = 1'b1;
`endif

  assign full     = (level_q == LVL_FULL);
  assign empty    = (level_q == '0);
  assign in_ready = ~full & ~flush;
  assign push     = in_valid & in_ready;
  // Flush suppresses a launch in the same cycle so nothing leaves after a discard.
  assign pop      = (state_q == Q_IDLE) & ~empty & ~uart_busy & ~flush & cts_ok;

  assign level    = level_q;
  assign all_sent = empty & (state_q == Q_IDLE) & ~uart_busy;
  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // NOTE: the storage array has no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= in_data;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
    end else begin
      level_q <= level_d;
      if (flush) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + PTR_ONE;
        if (pop)  head_q <= head_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= Q_IDLE;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      case (state_q)
        Q_IDLE: begin
          if (pop) begin
            tx_byte_q  <= mem_q[head_q];
            transmit_q <= 1'b1;
            state_q    <= Q_LAUNCH;
          end
        end
        Q_LAUNCH: begin
          transmit_q <= 1'b0;
          state_q    <= Q_WAIT_BUSY;
        end
        Q_WAIT_BUSY: begin
          if (uart_busy) state_q <= Q_WAIT_DONE;
        end
        Q_WAIT_DONE: begin
          if (!uart_busy) state_q <= Q_IDLE;
        end
        default: begin
          transmit_q <= 1'b0;
          state_q    <= Q_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomised bench for uart_tx_queue: a byte-queue reference model and a simple UART busy model.
module tb_uart_tx_queue;

  localparam int DEPTH_LOG2 = 4;
  localparam int FRAME      = 10;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                flush;
  logic [DEPTH_LOG2:0] level;
  logic                empty;
  logic                all_sent;
  logic                transmit;
  logic [7:0]          tx_byte;
  logic                uart_busy;
  logic                cts_n;
  logic                force_busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int          n_tx     = 0;
  logic        prev_tx  = 1'b0;
  logic        last_acc = 1'b0;
  int          busy_cnt = 0;
  logic [7:0]  exp_q [$];

  uart_tx_queue #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .level     (level),
    .empty     (empty),
    .all_sent  (all_sent),
    .transmit  (transmit),
    .tx_byte   (tx_byte),
    .uart_busy (uart_busy)
`ifdef UART_TX_QUEUE_CTS_EN
    ,
    .cts_n     (cts_n)
`endif
  );

  always #5 clk = ~clk;

  // UART stand-in: busy for FRAME cycles starting the cycle after it samples transmit.
  always @(posedge clk) begin
    if (rst)                        busy_cnt <= 0;
    else if (busy_cnt == 0 && transmit) busy_cnt <= FRAME;
    else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
  end
  assign uart_busy = (busy_cnt != 0) || force_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every launched byte must be the oldest byte still owed, single-cycle, into an idle UART.
  always @(negedge clk) begin
    if (rst) begin
      prev_tx = 1'b0;
    end else begin
      if (transmit) begin
        n_tx++;
        check("tx_width", 32'(prev_tx), 0);
        check("tx_overlap", 32'(uart_busy), 0);
        check("tx_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("tx_byte", 32'(tx_byte), 32'(exp_q.pop_front()));
      end
      prev_tx = transmit;
    end
  end

  task automatic drive_cycle(input logic v, input logic [7:0] d, input logic f);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    flush    = f;
    #1;
    last_acc = v && in_ready;
    if (f) exp_q.delete();
    else if (last_acc) exp_q.push_back(d);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || !all_sent) && i < budget) begin
      drive_cycle(1'b0, 8'h00, 1'b0);
      i++;
    end
    check(tag, 32'(exp_q.size() == 0 && all_sent), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int tx0;
    int k;
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0;
    cts_n = 1'b0; force_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_level", 32'(level), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_transmit", 32'(transmit), 0);
    check("rst_tx_byte", 32'(tx_byte), 0);
    check("rst_all_sent", 32'(all_sent), 1);

    // Single byte latency
    tx0 = n_tx;
    drive_cycle(1'b1, 8'hA5, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    check("lat_level_n1", 32'(level), 1);
    check("lat_tx_n1", 32'(transmit), 0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    check("lat_tx_n2", 32'(transmit), 1);
    check("lat_byte_n2", 32'(tx_byte), 32'h A5);
    check("lat_level_n2", 32'(level), 0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    check("lat_tx_n3", 32'(transmit), 0);
    check("lat_all_sent_busy", 32'(all_sent), 0);
    wait_drain("lat_drain", 40);
    check("lat_count", 32'(n_tx - tx0), 1);

    // Fill to full while the UART is held busy, then release
    tx0 = n_tx;
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 8'(i), 1'b0);
      check("fill_ready", 32'(in_ready), 1);
    end
    drive_cycle(1'b1, 8'hFF, 1'b0);
    check("full_ready", 32'(in_ready), 0);
    check("full_level", 32'(level), 16);
    drive_cycle(1'b0, 8'h00, 1'b0);
    check("full_hold_tx", 32'(n_tx - tx0), 0);
    force_busy = 1'b0;
    wait_drain("full_drain", 16 * (FRAME + 6));
    check("full_count", 32'(n_tx - tx0), 16);

    // Random-gap stream of 40 bytes through the 16-entry queue
    tx0 = n_tx; k = 0; guard = 0;
    while (k < 40 && guard < 3000) begin
      drive_cycle($urandom_range(0, 3) != 0, 8'(8'h40 + k), 1'b0);
      if (last_acc) k++;
      guard++;
    end
    check("stream_accepted", 32'(k), 40);
    wait_drain("stream_drain", 40 * (FRAME + 6));
    check("stream_count", 32'(n_tx - tx0), 40);

    // Flush while the first of five bytes is mid-frame
    tx0 = n_tx;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'(8'h10 + i), 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    check("flush_pre_level", 32'(level), 4);
    check("flush_pre_busy", 32'(uart_busy), 1);
    check("flush_pre_count", 32'(n_tx - tx0), 1);
    drive_cycle(1'b0, 8'h00, 1'b1);
    check("flush_in_ready", 32'(in_ready), 0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    check("flush_level", 32'(level), 0);
    check("flush_empty", 32'(empty), 1);
    wait_drain("flush_drain", 40);
    repeat (40) drive_cycle(1'b0, 8'h00, 1'b0);
    check("flush_count", 32'(n_tx - tx0), 1);

    // Reset while mid-frame with three bytes still queued
    tx0 = n_tx;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'h20 + i), 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    drive_cycle(1'b0, 8'h00, 1'b0);
    check("mrst_pre_level", 32'(level), 3);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_level", 32'(level), 0);
    check("mrst_transmit", 32'(transmit), 0);
    check("mrst_in_ready", 32'(in_ready), 1);
    check("mrst_all_sent", 32'(all_sent), 1);
    repeat (30) drive_cycle(1'b0, 8'h00, 1'b0);
    check("mrst_count", 32'(n_tx - tx0), 1);

`ifdef UART_TX_QUEUE_CTS_EN
    // Clear-to-send gating
    tx0 = n_tx;
    cts_n = 1'b1;
    drive_cycle(1'b1, 8'h30, 1'b0);
    drive_cycle(1'b1, 8'h31, 1'b0);
    repeat (100) drive_cycle(1'b0, 8'h00, 1'b0);
    check("cts_blocked", 32'(n_tx - tx0), 0);
    check("cts_level", 32'(level), 2);
    @(negedge clk);
    cts_n = 1'b0;
    for (int i = 0; i < 2 && n_tx == tx0; i++) drive_cycle(1'b0, 8'h00, 1'b0);
    check("cts_launch", 32'(n_tx - tx0), 1);
    wait_drain("cts_drain", 4 * (FRAME + 6));
    check("cts_count", 32'(n_tx - tx0), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
